// File: rtl/serial_mod_checker.sv
// Streaming divisibility checker: running remainder of a chunked number modulo DIVISOR.
// Chunks arrive MSB-first or LSB-first, framed by start/last strobes.
module serial_mod_checker #(
   parameter int DIVISOR   = 9,
   parameter int DW        = 1,
   parameter int MSB_FIRST = 1,
   localparam int RW       = $clog2(DIVISOR)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   input  logic          in_start,
   input  logic          in_last,
   output logic          out_valid,
   output logic [RW-1:0] remainder,
   output logic          divisible,
   output logic          err,
   output logic [15:0]   hit_count
);

   // state  | meaning
   // IDLE   | no frame open; only a start chunk is accepted
   // ACTIVE | frame open; chunks fold into rem/weight
   typedef enum logic {IDLE, ACTIVE} state_t;

   localparam int XW = RW + DW + 1;
   localparam logic [XW-1:0] DIV_X = XW'(DIVISOR);

   state_t        state;
   logic [RW-1:0] rem;
   logic [RW-1:0] weight;

   logic [RW-1:0] base_rem;
   logic [RW-1:0] base_w;
   logic [XW-1:0] msb_x;
   logic [XW-1:0] lsb_x;
   logic [XW-1:0] w_x;
   logic [XW-1:0] sum_x;
   logic [RW-1:0] rem_next;
   logic [RW-1:0] weight_next;
   logic          accept;
   logic          drop;

   always_comb begin
      base_rem    = in_start ? '0 : rem;
      base_w      = in_start ? RW'(1) : weight;
      msb_x       = {1'b0, base_rem, {DW{1'b0}}} + XW'(in_data);
      // LSB-first: each chunk is scaled by 2^(DW*k) mod DIVISOR, tracked in weight
      lsb_x       = XW'(base_rem) + XW'(in_data) * XW'(base_w);
      w_x         = XW'(base_w) << DW;
      sum_x       = (MSB_FIRST != 0) ? msb_x : lsb_x;
      rem_next    = RW'(sum_x % DIV_X);
      weight_next = RW'(w_x % DIV_X);
      accept      = in_valid && (state == ACTIVE || in_start);
      drop        = in_valid && (state == IDLE) && !in_start;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rem       <= '0;
         weight    <= RW'(1);
         out_valid <= 1'b0;
         remainder <= '0;
         divisible <= 1'b0;
         err       <= 1'b0;
         hit_count <= 16'h0000;
      end else begin
         out_valid <= 1'b0;
         err       <= drop;
         if (accept) begin
            rem    <= rem_next;
            weight <= weight_next;
            state  <= in_last ? IDLE : ACTIVE;
            if (in_last) begin
               out_valid <= 1'b1;
               remainder <= rem_next;
               divisible <= (rem_next == '0);
               if (rem_next == '0 && hit_count != 16'hFFFF)
                  hit_count <= hit_count + 16'h0001;
            end
         end
      end
   end

endmodule
